// File: rtl/mips_hazard_pkg.sv
// Shared types for the hazard scoreboard: table entry layout, forwarding encoding, FSM states.
package mips_hazard_pkg;

    // Entries carry a fixed-width rd so one struct serves every REG_ADDR_W up to 8.
    localparam int unsigned SB_RD_W = 8;

    typedef logic [SB_RD_W-1:0] sb_rd_t;

    typedef struct packed {
        logic   valid;
        sb_rd_t rd;
        logic   is_load;
    } sb_entry_t;

    localparam logic [2:0] FWD_RF = 3'd0;

    typedef enum logic {
        StRun,
        StFlush
    } hz_state_e;

endpackage

// File: rtl/hazard_sb_match.sv
// Priority matcher for one source operand: finds the newest in-flight producer of src_i.
module hazard_sb_match
    import mips_hazard_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  sb_entry_t [Depth-1:0] table_i,
    input  sb_rd_t                src_i,
    input  logic                  used_i,
    output logic                  hit_o,
    output logic [2:0]            k_o,
    output logic                  is_load_o
);

    // Scan oldest to newest so the smallest k overwrites any older hit.
    always_comb begin
        hit_o     = 1'b0;
        k_o       = 3'd0;
        is_load_o = 1'b0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (used_i && (src_i != '0) && table_i[i].valid && (table_i[i].rd == src_i)) begin
                hit_o     = 1'b1;
                k_o       = 3'(i);
                is_load_o = table_i[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard scoreboard: load-use stalls, registered EX forwarding selects and branch flushes.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned PIPE_DEPTH     = 3,
    parameter int unsigned LOAD_LAT       = 2,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [2:0]            fwd_a_ex,
    output logic [2:0]            fwd_b_ex,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    sb_entry_t [PIPE_DEPTH-1:0] table_q, table_d;
    sb_entry_t                  ins;
    hz_state_e                  state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [2:0]                 fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic                       hit_a, hit_b, load_a, load_b;
    logic [2:0]                 k_a, k_b;
    logic                       use_a, use_b, flush, stall_int, bubble;

    hazard_sb_match #(
        .Depth (PIPE_DEPTH)
    ) u_match_rs (
        .table_i   (table_q),
        .src_i     (sb_rd_t'(id_rs)),
        .used_i    (id_rs_used),
        .hit_o     (hit_a),
        .k_o       (k_a),
        .is_load_o (load_a)
    );

    hazard_sb_match #(
        .Depth (PIPE_DEPTH)
    ) u_match_rt (
        .table_i   (table_q),
        .src_i     (sb_rd_t'(id_rt)),
        .used_i    (id_rt_used),
        .hit_o     (hit_b),
        .k_o       (k_b),
        .is_load_o (load_b)
    );

    // A branch arriving during FLUSH comes from the squashed path and is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_branch_taken) begin
                    flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_d = StFlush;
                        cnt_d   = 3'(BRANCH_PENALTY - 1);
                    end
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Load data is not yet available when the producer sits before stage LOAD_LAT.
    assign use_a     = hit_a & load_a & ((32'(k_a) + 32'd1) < LOAD_LAT);
    assign use_b     = hit_b & load_b & ((32'(k_b) + 32'd1) < LOAD_LAT);
    assign stall_int = (use_a | use_b) & ~flush;
    assign bubble    = stall_int | flush;

    always_comb begin
        ins     = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!bubble) begin
            ins.valid   = id_valid & id_reg_write & (id_rd != '0);
            ins.rd      = sb_rd_t'(id_rd);
            ins.is_load = id_mem_read;
            if (hit_a) fwd_a_d = k_a + 3'd1;
            if (hit_b) fwd_b_d = k_b + 3'd1;
        end
        table_d = {table_q[PIPE_DEPTH-2:0], ins};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            table_q <= '0;
            state_q <= StRun;
            cnt_q   <= 3'd0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            table_q <= table_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign stall       = stall_int;
    assign flush_if_id = flush;
    assign flush_id_ex = flush;
    assign fwd_a_ex    = fwd_a_q;
    assign fwd_b_ex    = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             br_accept;

    assign br_accept = (state_q == StRun) & ex_branch_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_accept && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Scoreboard bench for hazard_scoreboard_ctrl (BRANCH_PENALTY=3, other parameters default).
module tb_hazard_scoreboard_ctrl;

    localparam int unsigned CntW = 16;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
    logic [4:0]      id_rs, id_rt, id_rd;
    logic            ex_branch_taken;
    logic            stall, flush_if_id, flush_id_ex;
    logic [2:0]      fwd_a_ex, fwd_b_ex;
    logic [CntW-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(
        .REG_ADDR_W     (5),
        .PIPE_DEPTH     (3),
        .LOAD_LAT       (2),
        .BRANCH_PENALTY (3),
        .CNT_W          (CntW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_used      (id_rs_used),
        .id_rt_used      (id_rt_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .fwd_a_ex        (fwd_a_ex),
        .fwd_b_ex        (fwd_b_ex),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    typedef struct {
        int         id;
        logic       stall;
        logic       flush;
        logic [2:0] fwd_a;
        logic [2:0] fwd_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return PerfEn ? 32'(n) : 32'd0;
    endfunction

    // One ID cycle, entered and left just after a falling edge.
    task automatic cyc(input int id, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br, input logic e_stall, input logic e_flush,
                       input logic [2:0] e_fa, input logic [2:0] e_fb);
        exp_t e;
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
        exp_q.push_back('{id, e_stall, e_flush, e_fa, e_fb});
        #1;
        e = exp_q[0];
        check($sformatf("c%0d stall", e.id), 32'(stall), 32'(e.stall));
        check($sformatf("c%0d flush_if_id", e.id), 32'(flush_if_id), 32'(e.flush));
        check($sformatf("c%0d flush_id_ex", e.id), 32'(flush_id_ex), 32'(e.flush));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("c%0d fwd_a_ex", e.id), 32'(fwd_a_ex), 32'(e.fwd_a));
        check($sformatf("c%0d fwd_b_ex", e.id), 32'(fwd_b_ex), 32'(e.fwd_b));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " flush_if_id"}, 32'(flush_if_id), 32'd0);
        check({tag, " flush_id_ex"}, 32'(flush_id_ex), 32'd0);
        check({tag, " fwd_a_ex"}, 32'(fwd_a_ex), 32'd0);
        check({tag, " fwd_b_ex"}, 32'(fwd_b_ex), 32'd0);
        check({tag, " stall_count"}, 32'(stall_count), 32'd0);
        check({tag, " flush_count"}, 32'(flush_count), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #3;
        check_cleared("reset");
        @(negedge clk);
        reset_n = 1'b1;

        //   id v  rs  rt ru tu rd rw mr br | stall flush fa fb
        cyc( 1, 1, 0,  0, 0, 0, 3, 1, 0, 0,   0,    0,    0, 0); // add r3
        cyc( 2, 1, 3,  2, 1, 1, 4, 1, 0, 0,   0,    0,    1, 0); // sub r4,r3,r2
        cyc( 3, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,    0,    0, 0);
        cyc( 4, 1, 0,  0, 0, 0, 5, 1, 1, 0,   0,    0,    0, 0); // lw r5
        cyc( 5, 1, 5,  1, 1, 1, 6, 1, 0, 0,   1,    0,    0, 0); // add r6,r5,r1: stall
        cyc( 6, 1, 5,  1, 1, 1, 6, 1, 0, 0,   0,    0,    2, 0); // retried
        check("stall_count after lw-use", 32'(stall_count), exp_cnt(1));
        cyc( 7, 1, 0,  0, 0, 0, 7, 1, 0, 0,   0,    0,    0, 0); // r7 (old)
        cyc( 8, 1, 0,  0, 0, 0, 8, 1, 0, 0,   0,    0,    0, 0); // r8
        cyc( 9, 1, 0,  0, 0, 0, 7, 1, 0, 0,   0,    0,    0, 0); // r7 (new)
        cyc(10, 1, 7,  8, 1, 1, 9, 1, 0, 0,   0,    0,    1, 2); // newest r7 wins
        cyc(11, 1, 0,  0, 0, 0, 0, 1, 1, 0,   0,    0,    0, 0); // lw r0
        cyc(12, 1, 0,  0, 1, 1, 9, 1, 0, 0,   0,    0,    0, 0); // reads r0
        cyc(13, 1, 0,  0, 0, 0,10, 1, 1, 0,   0,    0,    0, 0); // lw r10
        cyc(14, 1,10, 10, 0, 0, 0, 0, 0, 0,   0,    0,    0, 0); // r10 named but unused
        cyc(15, 1, 0,  0, 0, 0,11, 1, 1, 0,   0,    0,    0, 0); // lw r11
        cyc(16, 1, 1, 11, 1, 1,14, 1, 0, 0,   1,    0,    0, 0); // rt load-use
        cyc(17, 1, 1, 11, 1, 1,14, 1, 0, 0,   0,    0,    0, 2);
        check("stall_count after rt stall", 32'(stall_count), exp_cnt(2));
        cyc(18, 1, 0,  0, 0, 0,12, 1, 0, 1,   0,    1,    0, 0); // taken branch
        cyc(19, 0, 0,  0, 0, 0, 0, 0, 0, 1,   0,    1,    0, 0); // second pulse ignored
        cyc(20, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,    1,    0, 0);
        cyc(21, 1,12, 14, 1, 1, 0, 0, 0, 0,   0,    0,    0, 0); // r12 was squashed
        check("flush_count one branch", 32'(flush_count), exp_cnt(1));
        cyc(22, 1, 0,  0, 0, 0,13, 1, 1, 0,   0,    0,    0, 0); // lw r13
        cyc(23, 1,13,  0, 1, 0, 0, 0, 0, 1,   0,    1,    0, 0); // load-use + branch
        cyc(24, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0,    1,    0, 0);
        check("stall_count flush wins", 32'(stall_count), exp_cnt(2));
        check("flush_count two branches", 32'(flush_count), exp_cnt(2));

        // Reset asynchronously on the last FLUSH cycle.
        idle_inputs();
        #1;
        check("pre-reset flush_if_id", 32'(flush_if_id), 32'd1);
        reset_n = 1'b0;
        #1;
        check_cleared("mid-flush reset");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(25, 1,13, 13, 1, 1, 0, 0, 0, 0,   0,    0,    0, 0); // back in RUN, empty

        // Reset right after a load enters the table: the consumer must not see it.
        cyc(26, 1, 0,  0, 0, 0,15, 1, 1, 0,   0,    0,    0, 0); // lw r15
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset after lw stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(27, 1,15, 15, 1, 1, 0, 0, 0, 0,   0,    0,    0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
